// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg: one-hot state encoding and shared constants for the acc__ read/write scheduler.
package acc_sched_pkg;
    localparam int S_IDLE     = 0;
    localparam int S_WR       = 1;
    localparam int S_RD_ISSUE = 2;
    localparam int S_RD_WAIT  = 3;
    localparam int S_RD_DONE  = 4;
    localparam int N_STATES   = 5;
    localparam int CNT_W      = 4;
    localparam int DEF_RD_LAT = 1;
    localparam int G_WR       = 0;
    localparam int G_RD       = 1;
    typedef enum logic [N_STATES-1:0] {
        IDLE     = N_STATES'(1) << S_IDLE,
        WR       = N_STATES'(1) << S_WR,
        RD_ISSUE = N_STATES'(1) << S_RD_ISSUE,
        RD_WAIT  = N_STATES'(1) << S_RD_WAIT,
        RD_DONE  = N_STATES'(1) << S_RD_DONE
    } state_e;
endpackage

// File: rtl/acc_rr_pick2.sv
// acc_rr_pick2: 2-way round-robin pick; on a tie the channel not granted last wins.
module acc_rr_pick2
    import acc_sched_pkg::*;
(
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic       last_rd,
    output logic [1:0] gnt
);
    always_comb begin
        gnt       = '0;
        gnt[G_WR] = req_wr & (~req_rd | last_rd);
        gnt[G_RD] = req_rd & ~gnt[G_WR];
    end
endmodule

// File: rtl/acc_rw_sched.sv
// acc_rw_sched: serialises acc__ write and read requests onto one single-ported array port.
module acc_rw_sched
    import acc_sched_pkg::*;
#(
    parameter int axi4l__addr_width = 64,
    parameter int axi4l__data_width = 32,
    parameter int mem_addr_width    = 10,
    parameter int mem_rd_latency    = DEF_RD_LAT
) (
    input  logic                           sys__clk,
    input  logic                           sys__srstn,
    input  logic [axi4l__addr_width-1:0]   acc__waddr,
    input  logic [axi4l__data_width-1:0]   acc__wdata,
    input  logic [axi4l__data_width/8-1:0] acc__wstrb,
    input  logic                           acc__wvalid,
    output logic                           acc__wready,
    input  logic [axi4l__addr_width-1:0]   acc__raddr,
    input  logic                           acc__rvalid,
    output logic [axi4l__data_width-1:0]   acc__rdata,
    output logic                           acc__rready,
    output logic                           mem__en,
    output logic                           mem__we,
    output logic [mem_addr_width-1:0]      mem__addr,
    output logic [axi4l__data_width-1:0]   mem__wdata,
    output logic [axi4l__data_width/8-1:0] mem__wstrb,
    input  logic [axi4l__data_width-1:0]   mem__rdata
);
    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           last_rd_q, last_rd_d;
    logic [axi4l__data_width-1:0]   rdata_q, rdata_d;
    logic [1:0]                     gnt;
    logic                           unused_addr_bits;

    acc_rr_pick2 u_pick (
        .req_wr  (acc__wvalid),
        .req_rd  (acc__rvalid),
        .last_rd (last_rd_q),
        .gnt     (gnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE:     state_d = gnt[G_WR] ? WR : gnt[G_RD] ? RD_ISSUE : IDLE;
            WR: begin
                state_d   = IDLE;
                last_rd_d = 1'b0;
            end
            RD_ISSUE: begin
                state_d   = RD_WAIT;
                cnt_d     = CNT_W'(mem_rd_latency - 1);
                last_rd_d = 1'b1;
            end
            RD_WAIT: begin
                state_d = (cnt_q == '0) ? RD_DONE : RD_WAIT;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                rdata_d = (cnt_q == '0) ? mem__rdata : rdata_q;
            end
            RD_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys__clk) begin
        if (!sys__srstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_rd_q <= 1'b1;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_rd_q <= last_rd_d;
            rdata_q   <= rdata_d;
        end
    end

    // The array port mirrors the request payload only while its grant state is active.
    assign mem__en     = state_q[S_WR] | state_q[S_RD_ISSUE];
    assign mem__we     = state_q[S_WR];
    assign mem__addr   = state_q[S_WR]       ? acc__waddr[mem_addr_width+1:2] :
                         state_q[S_RD_ISSUE] ? acc__raddr[mem_addr_width+1:2] : '0;
    assign mem__wdata  = state_q[S_WR] ? acc__wdata : '0;
    assign mem__wstrb  = state_q[S_WR] ? acc__wstrb : '0;
    assign acc__wready = state_q[S_WR];
    assign acc__rready = state_q[S_RD_DONE];
    assign acc__rdata  = rdata_q;

    assign unused_addr_bits = ^{acc__waddr[axi4l__addr_width-1:mem_addr_width+2], acc__waddr[1:0],
                                acc__raddr[axi4l__addr_width-1:mem_addr_width+2], acc__raddr[1:0]};
endmodule

// File: doc/acc_rw_sched.md
# acc_rw_sched

Scheduler that shares one single-ported register/memory array between the write and read request channels of the AXI4-Lite slave interface's acc__ side. It accepts the acc__ write and read request channels, grants one request at a time with 2-way round-robin on ties, and drives the array port. Read data is returned after a fixed, parameterised array latency. It sits between the AXI4-Lite slave interface and the counter register bank.

## Interface
- axi4l__addr_width, 64, width of acc__waddr / acc__raddr
- axi4l__data_width, 32, data width; strobe width is axi4l__data_width/8
- mem_addr_width, 10, word-address width of the array port
- mem_rd_latency, 1, cycles from array enable (read) to valid mem__rdata; legal range 1..15

Ports:
- sys__clk  in  1  single clock, all logic on rising edge
- sys__srstn  in  1  reset, synchronous, active-low
- acc__waddr  in  axi4l__addr_width  write byte address
- acc__wdata  in  axi4l__data_width  write data
- acc__wstrb  in  axi4l__data_width/8  write byte strobes
- acc__wvalid  in  1  write request pending
- acc__wready  out  1  one-cycle pulse: write performed
- acc__raddr  in  axi4l__addr_width  read byte address
- acc__rvalid  in  1  read request pending
- acc__rdata  out  axi4l__data_width  read data, valid while acc__rready=1
- acc__rready  out  1  one-cycle pulse: read data available
- mem__en  out  1  array access enable
- mem__we  out  1  array write enable (qualified by mem__en)
- mem__addr  out  mem_addr_width  word address = acc addr bits [mem_addr_width+1:2]
- mem__wdata  out  axi4l__data_width  write data
- mem__wstrb  out  axi4l__data_width/8  byte strobes
- mem__rdata  in  axi4l__data_width  array read data, mem_rd_latency cycles after read enable

## Operation
- One-hot FSM with states IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE. Reset state is IDLE.
- IDLE:
  - wvalid only -> WR; rvalid only -> RD_ISSUE.
  - Both pending -> the channel not granted last. r_last_rd resets to 1, so a write wins the first tie.
  - Neither pending -> stay in IDLE.
- WR (1 cycle):
  - mem__en=1, mem__we=1.
  - mem__addr/wdata/wstrb are taken combinationally from acc__waddr/wdata/wstrb.
  - acc__wready=1; r_last_rd<=0; next state IDLE.
- RD_ISSUE (1 cycle):
  - mem__en=1, mem__we=0, mem__addr from acc__raddr.
  - Load wait counter with mem_rd_latency-1; r_last_rd<=1; next state RD_WAIT.
- RD_WAIT:
  - Counter nonzero -> decrement and stay.
  - Counter zero -> capture mem__rdata into r_rdata and go to RD_DONE.
  - With mem_rd_latency=1, RD_WAIT lasts exactly one cycle.
- RD_DONE (1 cycle): acc__rready=1, acc__rdata=r_rdata; next state IDLE.
- Outside WR and RD_ISSUE: mem__en=0, mem__we=0, and mem__addr/wdata/wstrb are driven 0.
- Address bits above mem_addr_width+1 and bits [1:0] are ignored. No range error is reported.
- Requests must hold valid and payload until their ready pulse. The block never samples a request while another is in flight.
- A request whose valid drops before grant is simply not serviced.

## Timing
- Reset values:
  - acc__wready=0, acc__rready=0, acc__rdata=0.
  - mem__en=0, mem__we=0, mem__addr=0, mem__wdata=0, mem__wstrb=0.
  - r_rdata=0, counter=0, state IDLE, r_last_rd=1.
- Write: request seen in IDLE at cycle T -> WR at T+1 (array write and wready at T+1) -> IDLE at T+2. Back-to-back write throughput is one per 2 cycles.
- Read: request seen at T:
  - RD_ISSUE at T+1.
  - mem__rdata captured at the end of cycle T+1+mem_rd_latency.
  - RD_DONE/acc__rready at T+2+mem_rd_latency; IDLE at T+3+mem_rd_latency.
- Simultaneous requests are serviced alternately, so neither channel starves. A pending loser is granted on the very next IDLE cycle.
- Reset mid-operation (any state) returns the block to IDLE next edge with all outputs at reset values. A read in flight is dropped and no ready pulse is issued.
- acc__wready and acc__rready are never high in the same cycle.

## Structure
- Shared package acc_sched_pkg holds:
  - one-hot state index localparams (IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE);
  - counter width (4 bits);
  - the default mem_rd_latency.
- One sub-module, acc_rr_pick2: a 2-way round-robin selector.
  - Inputs: req_wr, req_rd, last_rd.
  - Output: one-hot grant, combinational.
- The FSM, counter and capture register stay in acc_rw_sched.

## Test plan
- Single write, waddr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> WR one cycle after request; mem__addr=4, mem__we=1, acc__wready pulse once; read back returns 0xDEADBEEF.
- Single read, mem_rd_latency=3, raddr=0x10 -> mem__en one cycle after request; acc__rready exactly 5 cycles after request with acc__rdata=0xDEADBEEF.
- wvalid and rvalid asserted together from reset -> write granted first, read next; a repeated simultaneous pair then grants read first.
- Sustained simultaneous traffic of 8 writes and 8 reads -> grants strictly alternate; total 16 ready pulses; never both readies in one cycle.
- sys__srstn low during RD_WAIT -> no acc__rready; all outputs 0 next cycle; a subsequent read completes normally.
- Address 0xFFFF_FFFF_0000_1FFC with mem_addr_width=10 -> mem__addr=0x3FF, with the high bits ignored.
